alu_serial: RTL and testbench
=============================

# alu_serial

Parametrised, digit-serial successor to the team's 4-bit ripple ALU.
- Accepts two WIDTH-bit operands and a 3-bit op select over a valid/ready handshake.
- Processes SLICE bits per cycle, LSB slice first, through a carry-chained slice datapath.
- Returns the WIDTH-bit result with unsigned carry and signed overflow flags, held until the consumer accepts it.
- Sits wherever a narrow, low-area ALU can tolerate multi-cycle latency.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of SLICE
- SLICE, 4, bits processed per cycle; N = WIDTH/SLICE ≥ 1
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operands/op valid
- in_ready  out  1  block can accept; high only in IDLE
- a  in  WIDTH  operand
- b  in  WIDTH  operand
- s  in  3  op select
- out_valid  out  1  result valid; high only in DONE
- out_ready  in  1  consumer accepts result
- r  out  WIDTH  result
- c  out  1  unsigned carry
- v  out  1  signed overflow
- z, n  out  1 each  zero/negative flags; present only with ALU_ZN_FLAGS_EN

## Operation
- Op encoding:
  - 000 ADD a+b
  - 001 SUB a+~b+1
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 NOR
  - 110 INC a+1
  - 111 PASS b
- FSM states: IDLE, RUN, DONE. Reset → IDLE.
- Reset values: all outputs 0, except in_ready=1.
- IDLE:
  - On in_valid && in_ready: latch a, b, s; set carry register to 1 for SUB/INC, else 0; clear slice counter; go to RUN.
- RUN:
  - Each cycle, process slice k = counter, i.e. bits [k*SLICE +: SLICE].
  - Write the result slice into r_reg; update the carry register.
  - Counter wraps at N-1; after slice N-1, go to DONE.
- Flags (ADD/SUB/INC):
  - c = carry out of the MSB. For SUB, c=1 means no borrow.
  - v = carry into MSB XOR carry out of MSB.
  - Both taken from the final slice.
- Flags (AND/OR/XOR/NOR/PASS): c=0, v=0.
- DONE:
  - Hold r, c, v stable while out_ready is low.
  - On out_valid && out_ready, go to IDLE.
- in_valid is ignored outside IDLE.
- Operand inputs may change freely after acceptance.
- rst asserted in any state: immediate return to IDLE with reset output values. An in-flight op is discarded with no output.

## Timing
- Acceptance edge E0.
- Slices are processed on edges E1..EN.
- out_valid rises after EN, i.e. latency N cycles from acceptance edge to out_valid.
- in_ready rises the cycle after the output handshake edge.
- Minimum op period: N+2 cycles. No overlap of accept and deliver.
- N=1 (SLICE=WIDTH) is legal: a single RUN cycle.
- All outputs are registered; there is no combinational input-to-output path.

## Configuration
- ALU_ZN_FLAGS_EN defined:
  - z and n ports exist.
  - z=1 iff r==0; n=r[WIDTH-1]. Valid for all ops.
  - Both registered with r, and reset to 0.
- ALU_ZN_FLAGS_EN undefined: z and n ports and their logic are absent. Other behaviour is identical.

## Structure
- Package alu_pkg holds:
  - alu_op_e enum for the 3-bit op encodings
  - state enum (IDLE/RUN/DONE)
  - ALU_SEL_W=3
- Sub-module alu_slice, combinational and SLICE-wide:
  - Inputs: a, b, cin, s
  - Outputs: r, cout, c_msb_in (carry into the slice MSB, for v)
  - Instantiated once, reused each RUN cycle.

## Test plan
WIDTH=16, SLICE=4 unless noted.
- ADD 0x7FFF+0x0001 → r=0x8000, c=0, v=1; out_valid 4 cycles after the accept edge.
- SUB 0x0000−0x0001 → r=0xFFFF, c=0, v=0. SUB 0x8000−0x0001 → r=0x7FFF, c=1, v=1.
- ADD 0xFFFF+0x0001 → r=0x0000, c=1, v=0; with ALU_ZN_FLAGS_EN, z=1, n=0.
- AND 0xF0F0,0xFF00 → r=0xF000, c=0, v=0, n=1. Then NOR 0x0000,0x0000 → r=0xFFFF. Then PASS b=0x1234 → r=0x1234.
- Backpressure: out_ready held low 5 cycles while new in_valid pulses → r/c/v stable, in_ready=0, no new op accepted. Release → in_ready=1 next cycle.
- Reset mid-RUN (after 2 slices) → out_valid=0, r=0, in_ready=1 immediately. Next op gives a correct result. Repeat with SLICE=16 (N=1): latency 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the digit-serial ALU.
// Op encodings, FSM states and the op-select width.
package alu_pkg;

  localparam int ALU_SEL_W = 3;

  typedef enum logic [ALU_SEL_W-1:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_NOR  = 3'b101,
    OP_INC  = 3'b110,
    OP_PASS = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_slice.sv
// One SLICE-wide, carry-chained ALU slice (purely combinational).
// Logic ops force cout and c_msb_in low so flags come out as zero.
module alu_slice
  import alu_pkg::*;
#(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  input  alu_op_e          s,
  output logic [SLICE-1:0] r,
  output logic             cout,
  output logic             c_msb_in
);

  logic [SLICE-1:0] opb;
  logic [SLICE:0]   sum;
  logic             arith;

  always_comb begin
    opb   = b;
    arith = 1'b0;
    unique case (s)
      OP_ADD:  arith = 1'b1;
      OP_SUB:  begin opb = ~b; arith = 1'b1; end
      OP_INC:  begin opb = '0; arith = 1'b1; end
      default: arith = 1'b0;
    endcase
    sum = {1'b0, a} + {1'b0, opb}
        + {{SLICE{1'b0}}, cin};
    unique case (s)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b);
      OP_PASS: r = b;
      default: r = sum[SLICE-1:0];
    endcase
    cout = arith & sum[SLICE];
    // sum bit = a ^ b ^ carry-in, so the MSB carry-in falls out of it
    c_msb_in = arith
      & (sum[SLICE-1] ^ a[SLICE-1] ^ opb[SLICE-1]);
  end

endmodule

// File: rtl/alu_serial.sv
// Digit-serial ALU: SLICE bits per cycle, LSB slice first.
// Optional zero/negative flags with ALU_ZN_FLAGS_EN.
module alu_serial
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [ALU_SEL_W-1:0] s,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     r,
`ifdef ALU_ZN_FLAGS_EN
  output logic                 z,
  output logic                 n,
`endif
  output logic                 c,
  output logic                 v
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_e           state;
  alu_op_e          s_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [CW-1:0]    cnt;
  logic             cy;
  logic             last;

  logic [SLICE-1:0] sl_a;
  logic [SLICE-1:0] sl_b;
  logic [SLICE-1:0] sl_r;
  logic             sl_cout;
  logic             sl_cmsb;
  logic [WIDTH-1:0] r_nxt;

  assign last = (cnt == CW'(N - 1));

  always_comb begin
    sl_a = a_reg[cnt*SLICE +: SLICE];
    sl_b = b_reg[cnt*SLICE +: SLICE];
    r_nxt = r;
    r_nxt[cnt*SLICE +: SLICE] = sl_r;
  end

  alu_slice #(.SLICE(SLICE)) u_slice (
    .a        (sl_a),
    .b        (sl_b),
    .cin      (cy),
    .s        (s_reg),
    .r        (sl_r),
    .cout     (sl_cout),
    .c_msb_in (sl_cmsb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      s_reg     <= OP_ADD;
      a_reg     <= '0;
      b_reg     <= '0;
      cnt       <= '0;
      cy        <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      r         <= '0;
      c         <= 1'b0;
      v         <= 1'b0;
`ifdef ALU_ZN_FLAGS_EN
      z         <= 1'b0;
      n         <= 1'b0;
`endif
    end else begin
      unique case (state)
        ST_IDLE: if (in_valid) begin
          a_reg    <= a;
          b_reg    <= b;
          s_reg    <= alu_op_e'(s);
          cy       <= (alu_op_e'(s) == OP_SUB)
                   || (alu_op_e'(s) == OP_INC);
          cnt      <= '0;
          in_ready <= 1'b0;
          state    <= ST_RUN;
        end
        ST_RUN: begin
          r  <= r_nxt;
          cy <= sl_cout;
          if (last) begin
            cnt       <= '0;
            c         <= sl_cout;
            v         <= sl_cout ^ sl_cmsb;
`ifdef ALU_ZN_FLAGS_EN
            z         <= (r_nxt == '0);
            n         <= r_nxt[WIDTH-1];
`endif
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial.sv
// Directed bench for alu_serial: WIDTH=16 with SLICE=4 and SLICE=16.
// z/n checks are built only with ALU_ZN_FLAGS_EN.
module tb_alu_serial;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, rst1;
  logic        in_valid, in_valid1;
  logic        in_ready, in_ready1;
  logic [15:0] a, b, a1, b1;
  logic [2:0]  s, s1;
  logic        out_valid, out_valid1;
  logic        out_ready, out_ready1;
  logic [15:0] r, r1;
  logic        c, v, c1, v1;
`ifdef ALU_ZN_FLAGS_EN
  logic        z, n, z1, n1;
`endif

  int total = 0;
  int bad   = 0;
  int lat;
  logic [15:0] hold_r;
  logic        hold_c, hold_v;

  always #5 clk = ~clk;

  alu_serial #(.WIDTH(16), .SLICE(4)) u0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .s(s),
    .out_valid(out_valid), .out_ready(out_ready),
    .r(r),
`ifdef ALU_ZN_FLAGS_EN
    .z(z), .n(n),
`endif
    .c(c), .v(v)
  );

  alu_serial #(.WIDTH(16), .SLICE(16)) u1 (
    .clk(clk), .rst(rst1),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .s(s1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .r(r1),
`ifdef ALU_ZN_FLAGS_EN
    .z(z1), .n(n1),
`endif
    .c(c1), .v(v1)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Accept one op on u0 and wait (bounded) for out_valid.
  task automatic start_op(input logic [2:0] op,
                          input logic [15:0] x,
                          input logic [15:0] y);
    @(negedge clk);
    a = x; b = y; s = op; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    a = 16'hDEAD; b = 16'hBEEF; s = 3'b111;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1 lat++;
      if (out_valid) break;
    end
  endtask

  task automatic finish_op();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic run_op(input string tag,
                        input logic [2:0] op,
                        input logic [15:0] x,
                        input logic [15:0] y,
                        input logic [15:0] er,
                        input logic ec,
                        input logic ev);
    start_op(op, x, y);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".lat"}, 32'(lat), 32'd4);
    check({tag, ".r"}, 32'(r), 32'(er));
    check({tag, ".c"}, 32'(c), 32'(ec));
    check({tag, ".v"}, 32'(v), 32'(ev));
`ifdef ALU_ZN_FLAGS_EN
    check({tag, ".z"}, 32'(z), 32'(er == 16'h0));
    check({tag, ".n"}, 32'(n), 32'(er[15]));
`endif
    finish_op();
    check({tag, ".rdy"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; rst1 = 1'b1;
    in_valid = 1'b0; in_valid1 = 1'b0;
    out_ready = 1'b0; out_ready1 = 1'b0;
    a = '0; b = '0; s = '0;
    a1 = '0; b1 = '0; s1 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.in_ready", 32'(in_ready), 32'd1);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.r", 32'(r), 32'd0);
    check("rst.cv", 32'({c, v}), 32'd0);
    @(negedge clk);
    rst = 1'b0; rst1 = 1'b0;

    run_op("add_ovf", 3'b000, 16'h7FFF, 16'h0001,
           16'h8000, 1'b0, 1'b1);
    run_op("sub_brw", 3'b001, 16'h0000, 16'h0001,
           16'hFFFF, 1'b0, 1'b0);
    run_op("sub_ovf", 3'b001, 16'h8000, 16'h0001,
           16'h7FFF, 1'b1, 1'b1);
    run_op("add_cry", 3'b000, 16'hFFFF, 16'h0001,
           16'h0000, 1'b1, 1'b0);
    run_op("and", 3'b010, 16'hF0F0, 16'hFF00,
           16'hF000, 1'b0, 1'b0);
    run_op("nor", 3'b101, 16'h0000, 16'h0000,
           16'hFFFF, 1'b0, 1'b0);
    run_op("pass", 3'b111, 16'hAAAA, 16'h1234,
           16'h1234, 1'b0, 1'b0);
    run_op("or", 3'b011, 16'h0F00, 16'h00F0,
           16'h0FF0, 1'b0, 1'b0);
    run_op("xor", 3'b100, 16'hAAAA, 16'h5A5A,
           16'hF0F0, 1'b0, 1'b0);
    run_op("inc", 3'b110, 16'h00FF, 16'h9999,
           16'h0100, 1'b0, 1'b0);
    run_op("inc_wrap", 3'b110, 16'hFFFF, 16'h0000,
           16'h0000, 1'b1, 1'b0);

    // backpressure: result must hold, new requests ignored
    start_op(3'b000, 16'h1111, 16'h2222);
    check("bp.valid", 32'(out_valid), 32'd1);
    hold_r = 16'h3333; hold_c = 1'b0; hold_v = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = 16'(i * 7); b = 16'hFFFF; s = 3'b000;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      check("bp.r", 32'(r), 32'(hold_r));
      check("bp.cv", 32'({c, v}), 32'({hold_c, hold_v}));
      check("bp.in_ready", 32'(in_ready), 32'd0);
      check("bp.out_valid", 32'(out_valid), 32'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    finish_op();
    check("bp.rel_rdy", 32'(in_ready), 32'd1);
    check("bp.rel_ov", 32'(out_valid), 32'd0);

    // reset after two slices
    @(negedge clk);
    a = 16'h7FFF; b = 16'h7FFF; s = 3'b000;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mrst.out_valid", 32'(out_valid), 32'd0);
    check("mrst.r", 32'(r), 32'd0);
    check("mrst.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("mrst.no_out", 32'(out_valid), 32'd0);
    run_op("post_rst", 3'b001, 16'h1234, 16'h0234,
           16'h1000, 1'b1, 1'b0);

    // N=1 instance: single RUN cycle, reset mid-RUN
    @(negedge clk);
    a1 = 16'h7FFF; b1 = 16'h0001; s1 = 3'b000;
    in_valid1 = 1'b1;
    @(posedge clk);
    #1 in_valid1 = 1'b0;
    rst1 = 1'b1;
    #1;
    check("n1.rst_ov", 32'(out_valid1), 32'd0);
    check("n1.rst_rdy", 32'(in_ready1), 32'd1);
    @(negedge clk);
    rst1 = 1'b0;
    a1 = 16'h8000; b1 = 16'h0001; s1 = 3'b001;
    in_valid1 = 1'b1;
    @(posedge clk);
    #1 in_valid1 = 1'b0;
    check("n1.not_yet", 32'(out_valid1), 32'd0);
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 lat++;
      if (out_valid1) break;
    end
    check("n1.valid", 32'(out_valid1), 32'd1);
    check("n1.lat", 32'(lat), 32'd1);
    check("n1.r", 32'(r1), 32'h7FFF);
    check("n1.cv", 32'({c1, v1}), 32'b11);
`ifdef ALU_ZN_FLAGS_EN
    check("n1.zn", 32'({z1, n1}), 32'b00);
`endif
    @(negedge clk);
    out_ready1 = 1'b1;
    @(posedge clk);
    #1 out_ready1 = 1'b0;
    check("n1.rdy", 32'(in_ready1), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
